xip_line_buffer: RTL and testbench

//   Single-line read buffer between the CPU-side AXI4-Lite bus and the xip_engine slave port.

---
 rtl/xip_line_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_xip_line_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xip_line_buffer.sv
// Single-line read buffer between the CPU AXI4-Lite port and the xip_engine slave port.
// A read miss fills one aligned line word by word; writes pass through and drop the line.
module xip_line_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [31:0]           s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    output logic [ADDR_WIDTH-1:0] m_araddr_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [31:0]           m_rdata_i,
    input  logic [1:0]            m_rresp_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic [ADDR_WIDTH-1:0] m_awaddr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_wstrb_o,
    output logic                  m_awvalid_o,
    input  logic                  m_awready_i,
    output logic                  m_wvalid_o,
    input  logic                  m_wready_i,
    input  logic [1:0]            m_bresp_i,
    input  logic                  m_bvalid_i,
    output logic                  m_bready_o,
    input  logic                  invalidate_i,
    output logic                  line_valid_o,
    output logic                  hit_o
);
    localparam int LW = $clog2(LINE_WORDS);
    localparam int TW = ADDR_WIDTH - LW - 2;

    typedef enum logic [2:0] {IDLE, FILL_AR, FILL_R, RD_RESP, WR_REQ, WR_B, WR_RESP} state_t;

    state_t                       r_state, w_next;
    logic                         r_rdy;
    logic [TW-1:0]                r_tag;
    logic [LW-1:0]                r_word, r_k;
    logic [LINE_WORDS-1:0][31:0]  r_line;
    logic                         r_valid, r_err, r_inv_seen;
    logic                         r_rvalid, r_hit;
    logic [31:0]                  r_rdata;
    logic [1:0]                   r_rresp;
    logic [ADDR_WIDTH-1:0]        r_awaddr;
    logic [31:0]                  r_wdata;
    logic [3:0]                   r_wstrb;
    logic                         r_awv, r_wv;
    logic                         r_bvalid;
    logic [1:0]                   r_bresp;

    logic [TW-1:0] w_ar_tag;
    logic [LW-1:0] w_ar_word;
    logic          w_ar_acc, w_wr_acc, w_hit;
    logic          w_beat_err, w_last, w_err_nxt;
    logic [31:0]   w_fill_data;
    logic          w_unused;

    assign w_ar_tag   = s_araddr_i[ADDR_WIDTH-1:LW+2];
    assign w_ar_word  = s_araddr_i[LW+1:2];
    assign w_ar_acc   = r_rdy && (r_state == IDLE) && s_arvalid_i;
    assign w_wr_acc   = r_rdy && (r_state == IDLE) && !s_arvalid_i && s_awvalid_i && s_wvalid_i;
    assign w_hit      = w_ar_acc && r_valid && (w_ar_tag == r_tag);
    assign w_beat_err = (m_rresp_i != 2'b00);
    assign w_last     = (r_k == {LW{1'b1}});
    assign w_err_nxt  = r_err | w_beat_err;
    // The requested word may be the one arriving on this very beat.
    assign w_fill_data = (r_word == r_k) ? m_rdata_i : r_line[r_word];
    assign w_unused    = ^s_araddr_i[1:0];

    assign s_arready_o  = r_rdy;
    assign s_awready_o  = r_rdy;
    assign s_wready_o   = r_rdy;
    assign s_rvalid_o   = r_rvalid;
    assign s_rdata_o    = r_rdata;
    assign s_rresp_o    = r_rresp;
    assign s_bvalid_o   = r_bvalid;
    assign s_bresp_o    = r_bresp;
    assign m_araddr_o   = {r_tag, r_k, 2'b00};
    assign m_arvalid_o  = (r_state == FILL_AR);
    assign m_rready_o   = (r_state == FILL_R);
    assign m_awaddr_o   = r_awaddr;
    assign m_wdata_o    = r_wdata;
    assign m_wstrb_o    = r_wstrb;
    assign m_awvalid_o  = r_awv;
    assign m_wvalid_o   = r_wv;
    assign m_bready_o   = (r_state == WR_B);
    assign line_valid_o = r_valid;
    assign hit_o        = r_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_ar_acc)      w_next = w_hit ? RD_RESP : FILL_AR;
                else if (w_wr_acc) w_next = WR_REQ;
            end
            FILL_AR: if (m_arready_i) w_next = FILL_R;
            FILL_R:  if (m_rvalid_i)  w_next = (w_last || w_beat_err) ? RD_RESP : FILL_AR;
            RD_RESP: if (s_rready_i)  w_next = IDLE;
            WR_REQ:  if ((!r_awv || m_awready_i) && (!r_wv || m_wready_i)) w_next = WR_B;
            WR_B:    if (m_bvalid_i)  w_next = WR_RESP;
            WR_RESP: if (s_bready_i)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next == IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tag      <= '0;
            r_word     <= '0;
            r_k        <= '0;
            r_line     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_inv_seen <= 1'b0;
            r_rvalid   <= 1'b0;
            r_hit      <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= 2'b00;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awv      <= 1'b0;
            r_wv       <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ar_acc) begin
                        if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_line[w_ar_word];
                            r_rresp  <= 2'b00;
                            r_hit    <= 1'b1;
                        end else begin
                            r_tag      <= w_ar_tag;
                            r_word     <= w_ar_word;
                            r_k        <= '0;
                            r_err      <= 1'b0;
                            r_inv_seen <= 1'b0;
                            r_valid    <= 1'b0;
                        end
                    end else if (w_wr_acc) begin
                        r_awaddr <= s_awaddr_i;
                        r_wdata  <= s_wdata_i;
                        r_wstrb  <= s_wstrb_i;
                        r_awv    <= 1'b1;
                        r_wv     <= 1'b1;
                        r_valid  <= 1'b0;
                    end
                end
                FILL_AR: if (invalidate_i) r_inv_seen <= 1'b1;
                FILL_R: begin
                    if (invalidate_i) r_inv_seen <= 1'b1;
                    if (m_rvalid_i) begin
                        r_line[r_k] <= m_rdata_i;
                        r_err       <= w_err_nxt;
                        if (w_last || w_beat_err) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_err_nxt ? 32'h0 : w_fill_data;
                            r_rresp  <= w_err_nxt ? 2'b10 : 2'b00;
                            // A line touched by an invalidate mid-fill is served once, never cached.
                            r_valid  <= !w_err_nxt && !r_inv_seen && !invalidate_i;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                RD_RESP: if (s_rready_i) r_rvalid <= 1'b0;
                WR_REQ: begin
                    if (m_awready_i) r_awv <= 1'b0;
                    if (m_wready_i)  r_wv  <= 1'b0;
                end
                WR_B: begin
                    if (m_bvalid_i) begin
                        r_bresp  <= m_bresp_i;
                        r_bvalid <= 1'b1;
                    end
                end
                WR_RESP: if (s_bready_i) r_bvalid <= 1'b0;
                default: ;
            endcase
            if (invalidate_i) r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xip_line_buffer.sv
// Directed bench for xip_line_buffer with a small downstream slave model.
module tb_xip_line_buffer;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_araddr_i;
    logic        s_arvalid_i, s_arready_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic        s_rvalid_o, s_rready_i;
    logic [31:0] s_awaddr_i;
    logic        s_awvalid_i, s_awready_o;
    logic [31:0] s_wdata_i;
    logic [3:0]  s_wstrb_i;
    logic        s_wvalid_i, s_wready_o;
    logic [1:0]  s_bresp_o;
    logic        s_bvalid_o, s_bready_i;
    logic [31:0] m_araddr_o;
    logic        m_arvalid_o, m_arready_i;
    logic [31:0] m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rvalid_i, m_rready_o;
    logic [31:0] m_awaddr_o, m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i, m_bready_o;
    logic        invalidate_i, line_valid_o, hit_o;

    always #5 clk = ~clk;

    xip_line_buffer #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .m_awaddr_o(m_awaddr_o), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .invalidate_i(invalidate_i), .line_valid_o(line_valid_o), .hit_o(hit_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          ar_cnt = 0;
    int          aw_cnt = 0;
    int          err_at = -1;
    logic [31:0] ar_log [64];
    logic [31:0] aw_addr_log, w_data_log;
    logic [3:0]  w_strb_log;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Downstream slave: sample handshakes mid-cycle, respond just after the next edge.
    logic        hs_ar, hs_r, hs_aw, hs_w, hs_b, wv_seen, aw_done, w_done;
    logic [31:0] ar_a, aw_a, w_d;
    logic [3:0]  w_s;
    always begin
        @(negedge clk);
        hs_ar = m_arvalid_o && m_arready_i;  ar_a = m_araddr_o;
        hs_r  = m_rvalid_i && m_rready_o;
        hs_aw = m_awvalid_o && m_awready_i;  aw_a = m_awaddr_o;
        hs_w  = m_wvalid_o && m_wready_i;    w_d = m_wdata_o;  w_s = m_wstrb_o;
        hs_b  = m_bvalid_i && m_bready_o;
        wv_seen = m_wvalid_o;
        @(posedge clk);
        #1;
        if (!resetn) begin
            m_rvalid_i = 1'b0; m_bvalid_i = 1'b0; m_wready_i = 1'b0;
            aw_done = 1'b0; w_done = 1'b0;
        end else begin
            if (hs_r) m_rvalid_i = 1'b0;
            if (hs_ar) begin
                m_rvalid_i = 1'b1;
                m_rdata_i  = fdata(ar_a);
                m_rresp_i  = (ar_cnt == err_at) ? 2'b10 : 2'b00;
                ar_log[ar_cnt & 63] = ar_a;
                ar_cnt++;
            end
            if (hs_aw) begin aw_addr_log = aw_a; aw_cnt++; aw_done = 1'b1; end
            if (hs_w)  begin w_data_log = w_d; w_strb_log = w_s; w_done = 1'b1; end
            m_wready_i = hs_w ? 1'b0 : wv_seen;
            if (hs_b) m_bvalid_i = 1'b0;
            if (aw_done && w_done) begin
                m_bvalid_i = 1'b1; m_bresp_i = 2'b00; aw_done = 1'b0; w_done = 1'b0;
            end
        end
    end

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                            output int lat, output logic hit);
        int n;
        s_araddr_i = a; s_arvalid_i = 1'b1; s_rready_i = 1'b1;
        n = 0;
        while (!s_arready_o && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_arvalid_i = 1'b0;
        lat = 1;
        while (!s_rvalid_o && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("rd_rvalid", 32'(s_rvalid_o), 32'd1);
        d = s_rdata_o; r = s_rresp_o; hit = hit_o;
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] br);
        int n;
        s_awaddr_i = a; s_wdata_i = d; s_wstrb_i = s;
        s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
        n = 0;
        while (!s_awready_o && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
        n = 0;
        while (!s_bvalid_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("wr_bvalid", 32'(s_bvalid_o), 32'd1);
        br = s_bresp_o;
        @(posedge clk); #1;
        s_bready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    logic [31:0] d;
    logic [1:0]  r, br;
    int          lat, base, awb, n;
    logic        h;

    initial begin
        resetn = 1'b0; invalidate_i = 1'b0;
        s_araddr_i = '0; s_arvalid_i = 1'b0; s_rready_i = 1'b0;
        s_awaddr_i = '0; s_awvalid_i = 1'b0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = 1'b0;
        s_bready_i = 1'b0;
        m_arready_i = 1'b1; m_awready_i = 1'b1; m_wready_i = 1'b0;
        m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0; m_bresp_i = '0; m_bvalid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(s_arready_o), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid_o), 32'd0);
        chk("rst_rdata", s_rdata_o, 32'h0);
        chk("rst_bvalid", 32'(s_bvalid_o), 32'd0);
        chk("rst_m_arvalid", 32'(m_arvalid_o), 32'd0);
        chk("rst_line_valid", 32'(line_valid_o), 32'd0);
        chk("rst_hit", 32'(hit_o), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Cold miss fills 0x100..0x10C in order
        base = ar_cnt;
        axi_read(32'h100, d, r, lat, h);
        chk("fill_ar_count", ar_cnt - base, 32'd4);
        for (int i = 0; i < 4; i++) chk("fill_addr", ar_log[(base + i) & 63], 32'h100 + 32'(4 * i));
        chk("fill_rdata", d, 32'hC0DE_0100);
        chk("fill_rresp", 32'(r), 32'd0);
        chk("fill_line_valid", 32'(line_valid_o), 32'd1);

        // Hit on word 2
        base = ar_cnt;
        axi_read(32'h10A, d, r, lat, h);
        chk("hit_no_ar", ar_cnt - base, 32'd0);
        chk("hit_latency", lat, 32'd1);
        chk("hit_rdata", d, 32'hC0DE_0108);
        chk("hit_pulse", 32'(h), 32'd1);

        // Write passes through and drops the line
        awb = aw_cnt;
        axi_write(32'h104, 32'hDEAD_BEEF, 4'hF, br);
        chk("wr_count", aw_cnt - awb, 32'd1);
        chk("wr_awaddr", aw_addr_log, 32'h104);
        chk("wr_wdata", w_data_log, 32'hDEAD_BEEF);
        chk("wr_wstrb", 32'(w_strb_log), 32'hF);
        chk("wr_bresp", 32'(br), 32'd0);
        chk("wr_line_valid", 32'(line_valid_o), 32'd0);
        base = ar_cnt;
        axi_read(32'h104, d, r, lat, h);
        chk("post_wr_miss", ar_cnt - base, 32'd4);
        chk("post_wr_rdata", d, 32'hC0DE_0104);
        chk("post_wr_hit", 32'(h), 32'd0);

        // Error on beat 1 aborts the fill
        base = ar_cnt;
        err_at = ar_cnt + 1;
        axi_read(32'h200, d, r, lat, h);
        err_at = -1;
        chk("err_ar_count", ar_cnt - base, 32'd2);
        chk("err_rresp", 32'(r), 32'd2);
        chk("err_rdata", d, 32'h0);
        chk("err_line_valid", 32'(line_valid_o), 32'd0);

        // Invalidate during beat 2 of a fill
        base = ar_cnt;
        fork
            axi_read(32'h300, d, r, lat, h);
            begin
                n = 0;
                while (ar_cnt < base + 3 && n < 200) begin @(posedge clk); #2; n++; end
                invalidate_i = 1'b1;
                @(posedge clk); #1;
                invalidate_i = 1'b0;
            end
        join
        chk("inv_ar_count", ar_cnt - base, 32'd4);
        chk("inv_rresp", 32'(r), 32'd0);
        chk("inv_rdata", d, 32'hC0DE_0300);
        chk("inv_line_valid", 32'(line_valid_o), 32'd0);
        base = ar_cnt;
        axi_read(32'h300, d, r, lat, h);
        chk("inv_refill", ar_cnt - base, 32'd4);
        chk("refill_line_valid", 32'(line_valid_o), 32'd1);

        // Hit with R stalled for 5 cycles
        base = ar_cnt;
        s_araddr_i = 32'h30C; s_arvalid_i = 1'b1; s_rready_i = 1'b0;
        n = 0;
        while (!s_arready_o && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_arvalid_i = 1'b0;
        chk("stall_rvalid0", 32'(s_rvalid_o), 32'd1);
        chk("stall_hit0", 32'(hit_o), 32'd1);
        chk("stall_rdata0", s_rdata_o, 32'hC0DE_030C);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_rvalid", 32'(s_rvalid_o), 32'd1);
            chk("stall_rdata", s_rdata_o, 32'hC0DE_030C);
            chk("stall_arready", 32'(s_arready_o), 32'd0);
            chk("stall_hit_low", 32'(hit_o), 32'd0);
        end
        s_rready_i = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", 32'(s_rvalid_o), 32'd0);
        chk("stall_no_ar", ar_cnt - base, 32'd0);

        // AR and AW/W together: read first, then write
        awb = aw_cnt;
        s_araddr_i = 32'h304; s_arvalid_i = 1'b1;
        s_awaddr_i = 32'h308; s_wdata_i = 32'h1234_5678; s_wstrb_i = 4'h3;
        s_awvalid_i = 1'b1; s_wvalid_i = 1'b1; s_bready_i = 1'b1;
        n = 0;
        while (!s_arready_o && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_arvalid_i = 1'b0;
        chk("race_rvalid", 32'(s_rvalid_o), 32'd1);
        chk("race_rdata", s_rdata_o, 32'hC0DE_0304);
        chk("race_m_awvalid", 32'(m_awvalid_o), 32'd0);
        n = 0;
        while (!s_awready_o && n < 200) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_awvalid_i = 1'b0; s_wvalid_i = 1'b0;
        n = 0;
        while (!s_bvalid_o && n < 200) begin @(posedge clk); #1; n++; end
        chk("race_bvalid", 32'(s_bvalid_o), 32'd1);
        chk("race_wr_count", aw_cnt - awb, 32'd1);
        chk("race_awaddr", aw_addr_log, 32'h308);
        chk("race_wdata", w_data_log, 32'h1234_5678);
        chk("race_wstrb", 32'(w_strb_log), 32'h3);
        chk("race_line_valid", 32'(line_valid_o), 32'd0);
        @(posedge clk); #1;
        s_bready_i = 1'b0; s_rready_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
